// File: rtl/ir_rx_conditioner.sv
// Per-channel conditioner for active-low IR receiver pins: 2-flop synchronizer plus hysteretic integrator filter.
// Define ECLSENSOR_STUCK_DETECT_EN to add stuck-receiver detection and masking.
module ir_rx_conditioner #(
  parameter int unsigned kClockHz      = 25_000_000,
  parameter int unsigned kRxCount      = 20,
  parameter int unsigned kFilterBits   = 4,
  parameter int unsigned kOnThreshold  = 12,
  parameter int unsigned kOffThreshold = 3,
  parameter int unsigned kTickCycles   = 25_000,
  parameter int unsigned kStuckTicks   = 100
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [kRxCount-1:0] ir_rx_raw,
  output logic [kRxCount-1:0] ir_rx,
  output logic [kRxCount-1:0] stuck,
  output logic                any_stuck,
  input  logic                stuck_clear
);

  localparam logic [kFilterBits-1:0] kIntegMax = '1;
  localparam logic [kFilterBits-1:0] kOnLvl    = kFilterBits'(kOnThreshold);
  localparam logic [kFilterBits-1:0] kOffLvl   = kFilterBits'(kOffThreshold);

  logic [kRxCount-1:0]    r_s1;
  logic [kRxCount-1:0]    r_s2;
  logic [kRxCount-1:0]    r_f;
  logic [kRxCount-1:0]    r_ir_rx;
  logic [kRxCount-1:0]    w_f_nxt;
  logic [kRxCount-1:0]    w_stuck;
  logic [kFilterBits-1:0] r_integ     [kRxCount];
  logic [kFilterBits-1:0] w_integ_nxt [kRxCount];
  logic                   w_unused_cfg;

  // Saturating integrator step and hysteresis decision on the integrator's next value
  always_comb begin
    for (int n = 0; n < int'(kRxCount); n++) begin
      w_integ_nxt[n] = r_integ[n];
      w_f_nxt[n]     = r_f[n];
      if (!r_s2[n]) begin
        if (r_integ[n] != kIntegMax) w_integ_nxt[n] = r_integ[n] + kFilterBits'(1);
      end else if (r_integ[n] != '0) begin
        w_integ_nxt[n] = r_integ[n] - kFilterBits'(1);
      end
      if (w_integ_nxt[n] >= kOnLvl) begin
        w_f_nxt[n] = 1'b0;
      end else if (w_integ_nxt[n] <= kOffLvl) begin
        w_f_nxt[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1 <= '1;
      r_s2 <= '1;
      r_f  <= '1;
      for (int n = 0; n < int'(kRxCount); n++) r_integ[n] <= '0;
    end else begin
      r_s1 <= ir_rx_raw;
      r_s2 <= r_s1;
      r_f  <= w_f_nxt;
      for (int n = 0; n < int'(kRxCount); n++) r_integ[n] <= w_integ_nxt[n];
    end
  end

  // A stuck channel reads inactive so its downstream counter stays idle
  always_ff @(posedge clk) begin
    if (!reset_n) r_ir_rx <= '1;
    else          r_ir_rx <= r_f | w_stuck;
  end

  assign ir_rx = r_ir_rx;

`ifdef ECLSENSOR_STUCK_DETECT_EN
  localparam int unsigned       kPrescW   = (kTickCycles > 1) ? $clog2(kTickCycles) : 1;
  localparam int unsigned       kCntBits  = 8;
  localparam logic [kCntBits-1:0] kStuckLvl = kCntBits'(kStuckTicks);

  logic [kPrescW-1:0]  r_presc;
  logic                w_tick;
  logic [kCntBits-1:0] r_cnt [kRxCount];
  logic [kRxCount-1:0] r_stuck;
  logic                r_any_stuck;

  assign w_tick = (r_presc == kPrescW'(kTickCycles - 1));

  // Free-running prescaler; deliberately untouched by stuck_clear
  always_ff @(posedge clk) begin
    if (!reset_n)    r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + kPrescW'(1);
  end

  // Active-time tick counts; clear wins even on the edge a count would hit the limit
  always_ff @(posedge clk) begin
    if (!reset_n || stuck_clear) begin
      r_stuck <= '0;
      for (int n = 0; n < int'(kRxCount); n++) r_cnt[n] <= '0;
    end else begin
      for (int n = 0; n < int'(kRxCount); n++) begin
        if (r_f[n]) begin
          r_cnt[n] <= '0;
        end else if (w_tick && (r_cnt[n] != kStuckLvl)) begin
          r_cnt[n] <= r_cnt[n] + kCntBits'(1);
          if (r_cnt[n] == (kStuckLvl - kCntBits'(1))) r_stuck[n] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_any_stuck <= 1'b0;
    else          r_any_stuck <= |r_stuck;
  end

  assign w_stuck      = r_stuck;
  assign stuck        = r_stuck;
  assign any_stuck    = r_any_stuck;
  assign w_unused_cfg = (kClockHz == 0);
`else
  assign w_stuck      = '0;
  assign stuck        = '0;
  assign any_stuck    = 1'b0;
  assign w_unused_cfg = ^{stuck_clear, (kClockHz == 0), (kTickCycles == 0), (kStuckTicks == 0)};
`endif

endmodule

// File: tb/tb_ir_rx_conditioner.sv
// Directed bench for ir_rx_conditioner: filter latency, glitch rejection, chatter, stuck masking, reset.
module tb_ir_rx_conditioner;

  localparam int unsigned kRx    = 20;
  localparam int unsigned kTick  = 10;
  localparam int unsigned kStuck = 100;

  logic            clk         = 1'b0;
  logic            reset_n     = 1'b0;
  logic [kRx-1:0]  ir_rx_raw   = '1;
  logic            stuck_clear = 1'b0;
  logic [kRx-1:0]  ir_rx;
  logic [kRx-1:0]  stuck;
  logic            any_stuck;
  logic [kRx-1:0]  all1        = '1;

  int n_vec   = 0;
  int n_err   = 0;
  int edge_no = 0;

  always #5 clk = ~clk;

  // Edges since reset release; prescaler ticks fall on edges that are multiples of kTick
  always @(posedge clk) edge_no <= reset_n ? edge_no + 1 : 0;

  ir_rx_conditioner #(
    .kClockHz     (25_000_000),
    .kRxCount     (kRx),
    .kFilterBits  (4),
    .kOnThreshold (12),
    .kOffThreshold(3),
    .kTickCycles  (kTick),
    .kStuckTicks  (kStuck)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ir_rx_raw  (ir_rx_raw),
    .ir_rx      (ir_rx),
    .stuck      (stuck),
    .any_stuck  (any_stuck),
    .stuck_clear(stuck_clear)
  );

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge on which a channel's count reaches kStuck, counting ticks from edge 'start' onward
  function automatic int stuck_edge(input int start);
    int first;
    first = ((start + int'(kTick) - 1) / int'(kTick)) * int'(kTick);
    return first + (int'(kStuck) - 1) * int'(kTick);
  endfunction

  initial begin
    int e;
    int d;
    int t;
    int c;
    logic found;

    // Reset and idle
    clk_n(2);
    check("rst_ir_rx", ir_rx, all1);
    check("rst_stuck", stuck, 0);
    check("rst_any", any_stuck, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      clk_n(1);
      check("idle_ir_rx", ir_rx, all1);
      check("idle_stuck", stuck, 0);
      check("idle_any", any_stuck, 0);
    end

    // 11-clock glitch on channel 3 is absorbed
    ir_rx_raw[3] = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      clk_n(1);
      if (i == 11) ir_rx_raw[3] = 1'b1;
      check("glitch11", ir_rx[3], 1'b1);
    end

    // 12-clock pulse: falls after edge 15, integrator back to 3 at edge 23, output high at 24
    ir_rx_raw[3] = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      clk_n(1);
      if (i == 12) ir_rx_raw[3] = 1'b1;
      check("pulse12", ir_rx[3], (i >= 15 && i <= 23) ? 1'b0 : 1'b1);
    end
    check("pulse12_others", ir_rx, all1);

    // Channel 0 chatter 10 low / 2 high: integrator hits 12 at edge 18, output low from 19 on
    for (int i = 1; i <= 120; i++) begin
      ir_rx_raw[0] = (((i - 1) % 12) < 10) ? 1'b0 : 1'b1;
      clk_n(1);
      check("chatter", ir_rx[0], (i >= 19) ? 1'b0 : 1'b1);
    end
    ir_rx_raw[0] = 1'b1;
    clk_n(30);
    check("chatter_release", ir_rx, all1);
    check("chatter_stuck", stuck, 0);

`ifdef ECLSENSOR_STUCK_DETECT_EN
    // Channel 7 held low until declared stuck
    ir_rx_raw[7] = 1'b0;
    d = edge_no;
    t = stuck_edge(d + 15);
    clk_n(15);
    check("ch7_fall", ir_rx[7], 1'b0);
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      clk_n(1);
      if (stuck[7]) found = 1'b1;
    end
    check("ch7_stuck_seen", found, 1'b1);
    check("ch7_stuck_edge", edge_no, t);
    check("ch7_stuck_only", stuck, 32'h80);
    check("ch7_ir_same_edge", ir_rx[7], 1'b0);
    check("ch7_any_lag", any_stuck, 1'b0);
    clk_n(1);
    check("ch7_masked", ir_rx[7], 1'b1);
    check("ch7_any", any_stuck, 1'b1);
    clk_n(5);
    check("ch7_sticky", stuck[7], 1'b1);

    // Clear while still low: output falls one edge after the clear, then re-detect
    stuck_clear = 1'b1;
    clk_n(1);
    stuck_clear = 1'b0;
    c = edge_no;
    check("clr_stuck", stuck, 0);
    check("clr_ir_hold", ir_rx[7], 1'b1);
    check("clr_any_lag", any_stuck, 1'b1);
    clk_n(1);
    check("clr_ir_fall", ir_rx[7], 1'b0);
    check("clr_any", any_stuck, 1'b0);
    t = stuck_edge(c + 1);
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      clk_n(1);
      if (stuck[7]) found = 1'b1;
    end
    check("ch7_restuck_seen", found, 1'b1);
    check("ch7_restuck_edge", edge_no, t);
    ir_rx_raw[7] = 1'b1;
    stuck_clear  = 1'b1;
    clk_n(1);
    stuck_clear  = 1'b0;
    clk_n(30);
    check("ch7_done_ir", ir_rx, all1);
    check("ch7_done_any", any_stuck, 1'b0);

    // Clear on the exact edge channel 2's count would reach the limit
    ir_rx_raw[2] = 1'b0;
    d = edge_no;
    t = stuck_edge(d + 15);
    clk_n(t - 1 - d);
    check("race_pre", stuck[2], 1'b0);
    stuck_clear = 1'b1;
    clk_n(1);
    stuck_clear = 1'b0;
    check("race_stuck", stuck[2], 1'b0);
    check("race_ir", ir_rx[2], 1'b0);
    t = stuck_edge(t + 1);
    clk_n(t - 1 - edge_no);
    check("race_cnt_zero", stuck[2], 1'b0);
    clk_n(1);
    check("race_restuck", stuck[2], 1'b1);
    ir_rx_raw[2] = 1'b1;
    stuck_clear  = 1'b1;
    clk_n(1);
    stuck_clear  = 1'b0;
    clk_n(30);
    check("race_done", ir_rx, all1);
`else
    // Without detection a long hold stays active and nothing is flagged
    ir_rx_raw[7] = 1'b0;
    clk_n(1100);
    check("hold_ir", ir_rx[7], 1'b0);
    check("hold_stuck", stuck, 0);
    check("hold_any", any_stuck, 1'b0);
    stuck_clear = 1'b1;
    clk_n(1);
    stuck_clear = 1'b0;
    check("hold_clear_ignored", ir_rx[7], 1'b0);
    ir_rx_raw[7] = 1'b1;
    clk_n(30);
    check("hold_done", ir_rx, all1);
`endif

    // Reset mid-burst on all channels restarts the filter from idle
    ir_rx_raw = '0;
    clk_n(20);
    check("burst_all_low", ir_rx, 0);
    reset_n = 1'b0;
    clk_n(1);
    reset_n = 1'b1;
    check("midrst_ir", ir_rx, all1);
    check("midrst_stuck", stuck, 0);
    check("midrst_any", any_stuck, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      clk_n(1);
      e = i;
      check("midrst_latency", ir_rx, (e >= 15) ? 32'h0 : {12'h0, all1});
    end
    ir_rx_raw = '1;
    clk_n(30);
    check("final_idle", ir_rx, all1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
